// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready request, WAIT_STATES stall, byte/half/word access, valid/ready response.
// Optional access-fault checking is enabled by defining DMEM_ERR_EN.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LP_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_f3;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word;
  logic          w_bad_f3;
  logic          w_is_byte;
  logic          w_is_half;
  logic          w_misal;
  logic          w_oor;
  logic          w_err;
  logic          w_commit;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [3:0]    w_be;
  logic [31:0]   w_wrep;

  // With zero wait states the commit edge is the acceptance edge, so the live inputs are used then.
  assign w_we    = (r_state == S_IDLE) ? req_we     : r_we;
  assign w_addr  = (r_state == S_IDLE) ? req_addr   : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata  : r_wdata;
  assign w_f3    = (r_state == S_IDLE) ? req_funct3 : r_funct3;

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_bad_f3  = w_we ? (w_f3[2] || (w_f3[1:0] == 2'b11))
                     : ((w_f3 == 3'b011) || (w_f3[2:1] == 2'b11));
    w_is_byte = !w_bad_f3 && (w_f3[1:0] == 2'b00);
    w_is_half = !w_bad_f3 && (w_f3[1:0] == 2'b01);
    w_misal   = (w_is_half && w_addr[0]) ||
                (!w_is_byte && !w_is_half && (w_addr[1:0] != 2'b00));
    w_oor     = |w_addr[31:AW+2];

    w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
    w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];
    if (w_is_byte) begin
      w_load = w_f3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      w_be   = 4'b0001 << w_addr[1:0];
      w_wrep = {4{w_wdata[7:0]}};
    end else if (w_is_half) begin
      w_load = w_f3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      w_be   = w_addr[1] ? 4'b1100 : 4'b0011;
      w_wrep = {2{w_wdata[15:0]}};
    end else begin
      w_load = w_word;
      w_be   = '1;
      w_wrep = w_wdata;
    end
  end

`ifdef DMEM_ERR_EN
  assign w_err = w_bad_f3 || w_misal || w_oor;
`else
  // Without fault checking, addresses align down, indices wrap and bad funct3 acts as a word access.
  logic w_unused;
  assign w_err    = 1'b0;
  assign w_unused = ^{w_bad_f3, w_misal, w_oor};
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_commit = (r_state != S_RESP) && (w_next == S_RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_cnt    <= LP_CNT_INIT;
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_funct3 <= req_funct3;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_rdata <= (w_we || w_err) ? '0 : w_load;
        r_err   <= w_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_STATES=2; expectations follow DMEM_ERR_EN if defined.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at a negedge, hold until accepted, then scramble the request inputs.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = $urandom; req_funct3 = 3'b111;
  endtask

  // Count edges from acceptance (inclusive) until rsp_valid is seen; -1 marks a timeout.
  task automatic wait_rsp(output logic [31:0] o_rd, output logic o_er, output int o_lat);
    o_lat = 1;
    o_rd = 'x; o_er = 1'bx;
    forever begin
      @(negedge clk);
      if (rsp_valid) break;
      o_lat++;
      if (o_lat > 40) begin o_lat = -1; break; end
    end
    if (o_lat > 0) begin o_rd = rsp_rdata; o_er = rsp_err; end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, output logic [31:0] o_rd, output logic o_er,
                      output int o_lat);
    issue(we, addr, wdata, f3);
    wait_rsp(o_rd, o_er, o_lat);
    release_rsp();
  endtask

  initial begin
    #12;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err", {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word store then load, with latency
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
    chk("sw_latency", lat, 3);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", {31'h0, er}, 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
    chk("lw_latency", lat, 3);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'h0, er}, 32'h0);

    // Sub-word loads with extension
    xfer(1'b1, 32'h20, 32'h8070F0FF, 3'b010, rd, er, lat);
    xfer(1'b0, 32'h20, 32'h0, 3'b000, rd, er, lat);
    chk("lb_20", rd, 32'hFFFFFFFF);
    xfer(1'b0, 32'h21, 32'h0, 3'b100, rd, er, lat);
    chk("lbu_21", rd, 32'h000000F0);
    xfer(1'b0, 32'h22, 32'h0, 3'b001, rd, er, lat);
    chk("lh_22", rd, 32'hFFFF8070);
    xfer(1'b0, 32'h20, 32'h0, 3'b101, rd, er, lat);
    chk("lhu_20", rd, 32'h0000F0FF);
    xfer(1'b0, 32'h23, 32'h0, 3'b000, rd, er, lat);
    chk("lb_23", rd, 32'hFFFFFF80);
    xfer(1'b0, 32'h22, 32'h0, 3'b100, rd, er, lat);
    chk("lbu_22", rd, 32'h00000070);

    // Byte-enable stores
    xfer(1'b1, 32'h30, 32'h11223344, 3'b010, rd, er, lat);
    xfer(1'b1, 32'h31, 32'hFFFFFFAB, 3'b000, rd, er, lat);
    chk("sb_rdata", rd, 32'h0);
    xfer(1'b0, 32'h30, 32'h0, 3'b010, rd, er, lat);
    chk("after_sb", rd, 32'h1122AB44);
    xfer(1'b1, 32'h32, 32'h9999CDEF, 3'b001, rd, er, lat);
    xfer(1'b0, 32'h30, 32'h0, 3'b010, rd, er, lat);
    chk("after_sh", rd, 32'hCDEFAB44);

    // Response backpressure
    issue(1'b0, 32'h20, 32'h0, 3'b010);
    wait_rsp(rd, er, lat);
    chk("bp_first_rdata", rd, 32'h8070F0FF);
    held = rd;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rdata_stable", rsp_rdata, held);
      chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
    end
    release_rsp();
    chk("bp_release_req_ready", {31'h0, req_ready}, 32'h1);
    chk("bp_release_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    // Fault cases / fallback behaviour
    xfer(1'b1, 32'h0, 32'hA5A5A5A5, 3'b010, rd, er, lat);
    xfer(1'b0, 32'h13, 32'h0, 3'b010, rd, er, lat);
`ifdef DMEM_ERR_EN
    chk("lw_misal_err", {31'h0, er}, 32'h1);
    chk("lw_misal_rdata", rd, 32'h0);
`else
    chk("lw_misal_err", {31'h0, er}, 32'h0);
    chk("lw_misal_rdata", rd, 32'hDEADBEEF);
`endif
    xfer(1'b0, 32'h10, 32'h0, 3'b011, rd, er, lat);
`ifdef DMEM_ERR_EN
    chk("bad_f3_err", {31'h0, er}, 32'h1);
    chk("bad_f3_rdata", rd, 32'h0);
`else
    chk("bad_f3_err", {31'h0, er}, 32'h0);
    chk("bad_f3_rdata", rd, 32'hDEADBEEF);
`endif
    xfer(1'b1, 32'(4 * DEPTH), 32'h0BADF00D, 3'b010, rd, er, lat);
`ifdef DMEM_ERR_EN
    chk("sw_oor_err", {31'h0, er}, 32'h1);
`else
    chk("sw_oor_err", {31'h0, er}, 32'h0);
`endif
    xfer(1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
`ifdef DMEM_ERR_EN
    chk("word0_after_oor", rd, 32'hA5A5A5A5);
`else
    chk("word0_after_oor", rd, 32'h0BADF00D);
`endif

    // Reset during WAIT drops the captured store
    xfer(1'b1, 32'h40, 32'h0, 3'b010, rd, er, lat);
    issue(1'b1, 32'h40, 32'h12345678, 3'b010);
    rsp_ready = 1'b1;
    #2;
    chk("in_wait_req_ready", {31'h0, req_ready}, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'h0);
    rsp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    xfer(1'b0, 32'h40, 32'h0, 3'b010, rd, er, lat);
    chk("dropped_store", rd, 32'h0);
    chk("post_reset_latency", lat, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
